// File: rtl/bitmap_sram_responder.sv
// Bitmap row store with edge-triggered read/write requests, a power-up clear sweep,
// and fixed per-operation latency from request edge to done pulse.
module bitmap_sram_responder #(
    parameter int DATA_WIDTH     = 128,
    parameter int MAX_ADDR       = 512,
    parameter int ADDR_BIT_WIDTH = $clog2(MAX_ADDR),
    parameter int READ_LATENCY   = 2,
    parameter int WRITE_LATENCY  = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_read_req,
    input  logic                      i_write_req,
    input  logic [ADDR_BIT_WIDTH-1:0] i_read_addr,
    input  logic [ADDR_BIT_WIDTH-1:0] i_write_addr,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    output logic [DATA_WIDTH-1:0]     o_rdata,
    output logic                      o_or_rdata,
    output logic                      o_r_trans_done,
    output logic                      o_w_trans_done,
    output logic                      o_busy,
    output logic                      o_init_done
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0]          READ_LOAD  = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]          WRITE_LOAD = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [ADDR_BIT_WIDTH:0]   ADDR_LIMIT = (ADDR_BIT_WIDTH + 1)'(MAX_ADDR);
    localparam logic [ADDR_BIT_WIDTH-1:0] LAST_ROW   = ADDR_BIT_WIDTH'(MAX_ADDR - 1);

    typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     mem [MAX_ADDR];
    logic                      read_req_d;
    logic                      write_req_d;
    logic                      read_pend;
    logic                      write_pend;
    logic [ADDR_BIT_WIDTH-1:0] row_cnt;
    logic [ADDR_BIT_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0]     cap_data;
    logic [CNT_W-1:0]          lat_cnt;

    logic                      read_want;
    logic                      write_want;
    logic                      accept_read;
    logic                      accept_write;
    logic                      cap_in_range;
    logic [DATA_WIDTH-1:0]     read_row;
    logic                      mem_we;
    logic [ADDR_BIT_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]     mem_wdata;

    // A fresh edge counts as pending in the same cycle, so an idle block accepts on the
    // sampling edge itself; this is what makes a latency of 1 reachable.
    assign read_want    = read_pend  | (i_read_req  & ~read_req_d);
    assign write_want   = write_pend | (i_write_req & ~write_req_d);
    assign accept_write = (state == IDLE) && write_want;
    assign accept_read  = (state == IDLE) && !write_want && read_want;
    assign cap_in_range = {1'b0, cap_addr} < ADDR_LIMIT;
    assign read_row     = cap_in_range ? mem[cap_addr] : '0;

    assign mem_we    = (state == INIT) || ((state == WRITE) && (lat_cnt == '0) && cap_in_range);
    assign mem_waddr = (state == INIT) ? row_cnt : cap_addr;
    assign mem_wdata = (state == INIT) ? '0 : cap_data;

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= INIT;
            row_cnt        <= '0;
            read_req_d     <= 1'b0;
            write_req_d    <= 1'b0;
            read_pend      <= 1'b0;
            write_pend     <= 1'b0;
            cap_addr       <= '0;
            cap_data       <= '0;
            lat_cnt        <= '0;
            o_rdata        <= '0;
            o_or_rdata     <= 1'b0;
            o_r_trans_done <= 1'b0;
            o_w_trans_done <= 1'b0;
            o_busy         <= 1'b1;
            o_init_done    <= 1'b0;
        end else begin
            read_req_d     <= i_read_req;
            write_req_d    <= i_write_req;
            read_pend      <= read_want  & ~accept_read;
            write_pend     <= write_want & ~accept_write;
            o_r_trans_done <= 1'b0;
            o_w_trans_done <= 1'b0;
            case (state)
                INIT: begin
                    if (row_cnt == LAST_ROW) begin
                        state       <= IDLE;
                        o_busy      <= 1'b0;
                        o_init_done <= 1'b1;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (accept_write) begin
                        state    <= WRITE;
                        o_busy   <= 1'b1;
                        cap_addr <= i_write_addr;
                        cap_data <= i_wdata;
                        lat_cnt  <= WRITE_LOAD;
                    end else if (accept_read) begin
                        state    <= READ;
                        o_busy   <= 1'b1;
                        cap_addr <= i_read_addr;
                        lat_cnt  <= READ_LOAD;
                    end
                end
                READ: begin
                    if (lat_cnt == '0) begin
                        o_rdata        <= read_row;
                        o_or_rdata     <= |read_row;
                        o_r_trans_done <= 1'b1;
                        o_busy         <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                WRITE: begin
                    if (lat_cnt == '0) begin
                        o_w_trans_done <= 1'b1;
                        o_busy         <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= INIT;
                    o_busy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitmap_sram_responder.sv
// Bench for bitmap_sram_responder: vector table plus multi-cycle sequences, with a
// scoreboard queue of expected completions checked whenever a done pulse appears.
module tb_bitmap_sram_responder;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_read_req;
    logic       i_write_req;
    logic [2:0] i_read_addr;
    logic [2:0] i_write_addr;
    logic [7:0] i_wdata;
    logic [7:0] o_rdata;
    logic       o_or_rdata;
    logic       o_r_trans_done;
    logic       o_w_trans_done;
    logic       o_busy;
    logic       o_init_done;

    bitmap_sram_responder #(
        .DATA_WIDTH(8), .MAX_ADDR(6), .ADDR_BIT_WIDTH(3), .READ_LATENCY(2), .WRITE_LATENCY(1)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_read_req(i_read_req), .i_write_req(i_write_req),
        .i_read_addr(i_read_addr), .i_write_addr(i_write_addr), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_or_rdata(o_or_rdata),
        .o_r_trans_done(o_r_trans_done), .o_w_trans_done(o_w_trans_done),
        .o_busy(o_busy), .o_init_done(o_init_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_read;
        logic [7:0] data;
        int         issue;
        int         lat;
    } sb_t;

    typedef struct {
        logic       is_write;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        int         lat;
    } vec_t;

    sb_t        sb[$];
    vec_t       vecs[12];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_rdata;
    logic       prev_r;
    logic       prev_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    task automatic checkOutput();
        sb_t e;
        if (o_r_trans_done || o_w_trans_done) begin
            check("both_done", 32'(o_r_trans_done & o_w_trans_done), 32'd0);
            check("done_after_init", 32'(o_init_done), 32'd1);
            check("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("done_kind", 32'(o_r_trans_done), 32'(e.is_read));
                if (e.lat >= 0) check("done_latency", 32'(cyc - e.issue), 32'(e.lat));
                if (e.is_read) begin
                    check("rdata", 32'(o_rdata), 32'(e.data));
                    check("or_rdata", 32'(o_or_rdata), 32'(|e.data));
                    last_rdata = e.data;
                end else begin
                    check("rdata_held", 32'(o_rdata), 32'(last_rdata));
                end
            end
        end
        if (o_r_trans_done) check("r_done_width", 32'(prev_r), 32'd0);
        if (o_w_trans_done) check("w_done_width", 32'(prev_w), 32'd0);
        prev_r = o_r_trans_done;
        prev_w = o_w_trans_done;
    endtask

    task automatic tick();
        @(negedge i_clk);
        checkOutput();
    endtask

    task automatic pushExp(input logic is_read, input logic [7:0] data, input int lat);
        sb.push_back('{is_read, data, cyc + 1, lat});
    endtask

    task automatic applyStimulus(input logic is_write, input logic [2:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] exp_rdata,
                                 input int lat);
        if (is_write) begin
            i_write_req  = 1'b1;
            i_write_addr = addr;
            i_wdata      = wdata;
            pushExp(1'b0, 8'h00, lat);
        end else begin
            i_read_req  = 1'b1;
            i_read_addr = addr;
            pushExp(1'b1, exp_rdata, lat);
        end
        tick();
        i_read_req  = 1'b0;
        i_write_req = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((sb.size() != 0 || o_busy) && n < 40) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(sb.size() != 0 || o_busy), 32'd0);
    endtask

    task automatic waitInit(input int c0);
        int n = 0;
        while (!o_init_done && n < 20) begin
            tick();
            n++;
        end
        check("init_done_cycles", 32'(cyc - c0), 32'd6);
        check("busy_after_init", 32'(o_busy), 32'd0);
    endtask

    initial begin
        int c0;
        vecs[0]  = '{1'b0, 3'd3, 8'h00, 8'h00, 2};
        vecs[1]  = '{1'b1, 3'd2, 8'h81, 8'h00, 1};
        vecs[2]  = '{1'b0, 3'd2, 8'h00, 8'h81, 2};
        vecs[3]  = '{1'b1, 3'd7, 8'hFF, 8'h00, 1};
        vecs[4]  = '{1'b0, 3'd7, 8'h00, 8'h00, 2};
        vecs[5]  = '{1'b1, 3'd5, 8'h3C, 8'h00, 1};
        vecs[6]  = '{1'b0, 3'd5, 8'h00, 8'h3C, 2};
        vecs[7]  = '{1'b0, 3'd0, 8'h00, 8'h00, 2};
        vecs[8]  = '{1'b0, 3'd4, 8'h00, 8'h00, 2};
        vecs[9]  = '{1'b1, 3'd4, 8'h7E, 8'h00, 1};
        vecs[10] = '{1'b0, 3'd4, 8'h00, 8'h7E, 2};
        vecs[11] = '{1'b0, 3'd2, 8'h00, 8'h81, 2};

        i_rst_n = 1'b0; i_read_req = 1'b0; i_write_req = 1'b0;
        i_read_addr = '0; i_write_addr = '0; i_wdata = '0;
        last_rdata = 8'h00; prev_r = 1'b0; prev_w = 1'b0;
        repeat (3) tick();
        check("reset_rdata", 32'(o_rdata), 32'd0);
        check("reset_or", 32'(o_or_rdata), 32'd0);
        check("reset_r_done", 32'(o_r_trans_done), 32'd0);
        check("reset_w_done", 32'(o_w_trans_done), 32'd0);
        check("reset_init_done", 32'(o_init_done), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd1);

        i_rst_n = 1'b1;
        c0 = cyc;
        waitInit(c0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].is_write, vecs[i].addr, vecs[i].wdata,
                          vecs[i].exp_rdata, vecs[i].lat);
            waitIdle();
        end

        // Same-cycle write and read of one row: write completes first, read sees new data.
        i_write_req = 1'b1; i_write_addr = 3'd1; i_wdata = 8'h10;
        i_read_req  = 1'b1; i_read_addr  = 3'd1;
        pushExp(1'b0, 8'h00, 1);
        pushExp(1'b1, 8'h10, -1);
        tick();
        i_write_req = 1'b0; i_read_req = 1'b0;
        waitIdle();

        // A held request yields exactly one read.
        i_read_req = 1'b1; i_read_addr = 3'd5;
        pushExp(1'b1, 8'h3C, 2);
        repeat (10) tick();
        i_read_req = 1'b0;
        waitIdle();
        repeat (4) tick();

        applyStimulus(1'b1, 3'd0, 8'h55, 8'h00, 1);
        waitIdle();

        // Reset lands one cycle before the read would complete.
        i_read_req = 1'b1; i_read_addr = 3'd0;
        tick();
        tick();
        i_read_req = 1'b0;
        i_rst_n = 1'b0;
        last_rdata = 8'h00;
        #1;
        check("abort_rdata", 32'(o_rdata), 32'd0);
        check("abort_r_done", 32'(o_r_trans_done), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd1);
        repeat (2) tick();
        check("abort_no_done", 32'(o_r_trans_done), 32'd0);

        // Read edge during the clear sweep is served once the sweep finishes.
        i_rst_n = 1'b1;
        c0 = cyc;
        tick();
        tick();
        i_read_req = 1'b1; i_read_addr = 3'd0;
        pushExp(1'b1, 8'h00, -1);
        tick();
        i_read_req = 1'b0;
        waitInit(c0);
        waitIdle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bitmap_sram_responder.md
BITMAP_SRAM_RESPONDER -- requirements
Module: bitmap_sram_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: bits per row, one bit per host.
REQ-002 SHALL have parameter MAX_ADDR, default 512: number of rows, one row per plane.
REQ-003 SHALL have parameter ADDR_BIT_WIDTH, default $clog2(MAX_ADDR): address width.
REQ-004 SHALL have parameter READ_LATENCY, default 2: cycles from acceptance to read done; legal range is 1 or more.
REQ-005 SHALL have parameter WRITE_LATENCY, default 1: cycles from acceptance to write done; legal range is 1 or more.
REQ-006 SHALL have port i_clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port i_read_req, input, 1 bit: level read request; a rising edge starts one read.
REQ-009 SHALL have port i_write_req, input, 1 bit: level write request; a rising edge starts one write.
REQ-010 SHALL have port i_read_addr, input, ADDR_BIT_WIDTH bits: read row.
REQ-011 SHALL have port i_write_addr, input, ADDR_BIT_WIDTH bits: write row.
REQ-012 SHALL have port i_wdata, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port o_rdata, output, DATA_WIDTH bits: last completed read data, registered.
REQ-014 SHALL have port o_or_rdata, output, 1 bit: reduction-OR of o_rdata, registered in the same cycle as o_rdata.
REQ-015 SHALL have port o_r_trans_done, output, 1 bit: read-complete pulse, one cycle wide.
REQ-016 SHALL have port o_w_trans_done, output, 1 bit: write-complete pulse, one cycle wide.
REQ-017 SHALL have port o_busy, output, 1 bit: high when the state is not IDLE.
REQ-018 SHALL have port o_init_done, output, 1 bit: memory clear sweep complete.

Function
REQ-019 SHALL store MAX_ADDR rows of DATA_WIDTH bits in an internal register array.
REQ-020 SHALL implement a four-state FSM: INIT, IDLE, READ, WRITE.
REQ-021 SHALL, in INIT, clear one row per cycle in order 0..MAX_ADDR-1, then enter IDLE; o_init_done rises on the same edge and stays high until reset.
REQ-022 SHALL detect request edges by registering each request: edge = req & ~req_d.
REQ-023 SHALL, on an edge, set a one-deep pending flag per request type; a second edge of the same type while that flag is set merges into it and is dropped.
REQ-024 SHALL detect and latch edges in every state, including INIT; a request held high produces exactly one transaction.
REQ-025 SHALL accept from IDLE on the edge after a pending flag is seen; when both flags are set, write goes first.
REQ-026 SHALL, on acceptance, clear the accepted pending flag, capture the address (and i_wdata for writes), and load the latency counter.
REQ-027 SHALL set latency so that a read edge sampled at edge E0, with the block idle and nothing pending, raises o_r_trans_done at edge E0+READ_LATENCY; writes behave the same with WRITE_LATENCY.
REQ-028 SHALL, on the done edge of a write, write mem[addr] <= captured data; pulse o_w_trans_done; return to IDLE.
REQ-029 SHALL, on the done edge of a read, load o_rdata <= mem[addr] and o_or_rdata <= |mem[addr]; pulse o_r_trans_done; return to IDLE.
REQ-030 SHALL hold o_rdata and o_or_rdata stable until the next read completes.
REQ-031 SHALL, for an address >= MAX_ADDR: on a write, leave memory unchanged and still pulse done; on a read, return all zeros and still pulse done.
REQ-032 SHALL, for simultaneous read and write edges to the same address, have the read return the newly written data.
REQ-033 SHALL never assert both done pulses in the same cycle, and SHALL process at most one transaction at a time.
REQ-034 SHALL allow the minimum gap between consecutive transactions to be one IDLE cycle.

Reset
REQ-035 SHALL, when i_rst_n is low, drive o_rdata=0, o_or_rdata=0, both done=0, o_init_done=0, o_busy=1, clear pending flags and req_d, and set state=INIT with the row counter at 0.
REQ-036 SHALL abort any in-flight transaction on reset with no done pulse; INIT re-clears all rows.

Verification
Bench parameters: DATA_WIDTH=8, MAX_ADDR=6, ADDR_BIT_WIDTH=3, READ_LATENCY=2, WRITE_LATENCY=1.
REQ-037 SHALL cover: release reset -> o_init_done high exactly 6 cycles later; read addr 3 -> o_rdata=0x00, o_or_rdata=0, one r_done pulse 2 cycles after the edge.
REQ-038 SHALL cover: write addr 2, data 0x81 -> w_done 1 cycle after the edge; then read addr 2 -> o_rdata=0x81, o_or_rdata=1.
REQ-039 SHALL cover: write addr 1, data 0x10, and read addr 1 with edges in the same cycle -> w_done first, then r_done with o_rdata=0x10.
REQ-040 SHALL cover: i_read_req held high for 10 cycles -> exactly one r_done pulse; an edge during INIT -> served after o_init_done rises.
REQ-041 SHALL cover: write addr 7, data 0xFF, then read addr 7 -> both done pulses occur, o_rdata=0x00, no row modified.
REQ-042 SHALL cover: reset asserted mid-read, after writing 0x55 to addr 0 -> no r_done, o_rdata=0; after the re-init, a read of addr 0 returns 0x00.
